// File: rtl/mmio_controller.sv
// mmio_controller
//   Decodes CPU accesses into either block memory (mem_sel) or one of NUM_CH
//   MMIO channels living in the 4 KiB page addr[31:12] == MMIO_BASE.
//   addr[11:8] picks the channel, addr[7:0] is the register offset.
//   An MMIO access is latched, strobed to the channel for one cycle (ISSUE),
//   then the block waits for that channel's ack (WAIT) and completes in RESP.
//
// Ports
//   clk, Rst                       clock, asynchronous active-low reset
//   req_addr/req_rd/req_wr/req_din CPU access
//   req_hold                       CPU stall while an MMIO access is in flight
//   req_dout/req_err               completion data / error, held until next MMIO completion
//   mem_sel                        access targets block memory
//   ch_sel/ch_rd/ch_wr             one-cycle channel strobes
//   ch_addr/ch_din                 latched register offset / write data
//   ch_dout/ch_ack                 channel responses (channel i at ch_dout[i*DATA_W +: DATA_W])
//
// Build option
//   MMIO_TIMEOUT_EN  when defined, a WAIT longer than TIMEOUT cycles completes
//                    with req_err=1 and a 0xDEADBEEF fill pattern.
module mmio_controller #(
  parameter int          NUM_CH    = 4,
  parameter int          DATA_W    = 32,
  parameter logic [19:0] MMIO_BASE = 20'hAAAAA,
  parameter int          TIMEOUT   = 16
) (
  input  logic                     clk,
  input  logic                     Rst,
  input  logic [31:0]              req_addr,
  input  logic                     req_rd,
  input  logic                     req_wr,
  input  logic [DATA_W-1:0]        req_din,
  output logic                     req_hold,
  output logic [DATA_W-1:0]        req_dout,
  output logic                     req_err,
  output logic                     mem_sel,
  output logic [NUM_CH-1:0]        ch_sel,
  output logic                     ch_rd,
  output logic                     ch_wr,
  output logic [7:0]               ch_addr,
  output logic [DATA_W-1:0]        ch_din,
  input  logic [NUM_CH*DATA_W-1:0] ch_dout,
  input  logic [NUM_CH-1:0]        ch_ack
);

  if (NUM_CH < 1 || NUM_CH > 16 || TIMEOUT < 1) begin : g_param_check
    $error("mmio_controller: NUM_CH must be 1..16 and TIMEOUT >= 1");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            state, state_nxt;
  logic              acc, is_mmio, idx_ok, accept;
  logic [3:0]        idx_in, idx_r;
  logic              rd_r, wr_r;
  logic              sel_ack, tmo;
  logic [DATA_W-1:0] sel_data;

  assign acc     = req_rd | req_wr;
  assign is_mmio = (req_addr[31:12] == MMIO_BASE);
  assign idx_in  = req_addr[11:8];
  assign idx_ok  = 32'(idx_in) < 32'(NUM_CH);
  assign mem_sel = acc & ~is_mmio;
  assign accept  = (state == IDLE) & acc & is_mmio;

  // Ack/data of the latched channel only; other channels' acks are ignored.
  always_comb begin
    sel_ack  = 1'b0;
    sel_data = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (idx_r == 4'(i)) begin
        sel_ack  = ch_ack[i];
        sel_data = ch_dout[i*DATA_W +: DATA_W];
      end
    end
  end

`ifdef MMIO_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [31:0] DEAD_PAT = 32'hDEADBEEF;
  logic [CNT_W-1:0] tcnt;

  function automatic logic [DATA_W-1:0] dead_fill();
    logic [DATA_W-1:0] f;
    for (int unsigned i = 0; i < DATA_W; i++) f[i] = DEAD_PAT[i % 32];
    return f;
  endfunction

  // tcnt holds the number of completed WAIT cycles; the TIMEOUT-th WAIT
  // cycle is the last one, and an ack in that cycle still wins.
  assign tmo = (state == WAIT) && (tcnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst)                   tcnt <= '0;
    else if (state_nxt == ISSUE) tcnt <= '0;
    else if (state == WAIT)     tcnt <= tcnt + 1'b1;
  end
`else
  assign tmo = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = idx_ok ? ISSUE : RESP;
      ISSUE:   state_nxt = sel_ack ? RESP : WAIT;
      WAIT:    if (sel_ack || tmo) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request latch and completion capture
  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      idx_r    <= '0;
      rd_r     <= 1'b0;
      wr_r     <= 1'b0;
      ch_addr  <= '0;
      ch_din   <= '0;
      req_dout <= '0;
      req_err  <= 1'b0;
    end else begin
      if (accept) begin
        idx_r   <= idx_in;
        rd_r    <= req_rd;
        wr_r    <= req_wr;
        ch_addr <= req_addr[7:0];
        ch_din  <= req_din;
        if (!idx_ok) begin
          req_dout <= '0;
          req_err  <= 1'b1;
        end
      end else if ((state == ISSUE || state == WAIT) && sel_ack) begin
        req_dout <= sel_data;
        req_err  <= 1'b0;
      end
`ifdef MMIO_TIMEOUT_EN
      else if (tmo) begin
        req_dout <= dead_fill();
        req_err  <= 1'b1;
      end
`endif
    end
  end

  // Outputs; hold is gated by Rst so a request pending during reset does not stall.
  always_comb begin
    req_hold = Rst & (accept | (state == ISSUE) | (state == WAIT));
    ch_sel   = '0;
    ch_rd    = 1'b0;
    ch_wr    = 1'b0;
    if (state == ISSUE) begin
      for (int unsigned i = 0; i < NUM_CH; i++) ch_sel[i] = (idx_r == 4'(i));
      ch_rd = rd_r;
      ch_wr = wr_r;
    end
  end

endmodule
